// File: rtl/mmp_dac_pkg.sv
// Shared constants and state encoding for the DAC mix scheduler and its
// saturation helper.
package mmp_dac_pkg;

    localparam int SMP_W      = 16;
    localparam int GAIN_W     = 4;
    localparam int GAIN_UNITY = 8;
    localparam int ACC_W      = 22;

    localparam logic [1:0] CFG_SCC    = 2'd0;
    localparam logic [1:0] CFG_PSG    = 2'd1;
    localparam logic [1:0] CFG_OPLL   = 2'd2;
    localparam logic [1:0] CFG_MASTER = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MAC0 = 3'd1,
        ST_MAC1 = 3'd2,
        ST_MAC2 = 3'd3,
        ST_SAT  = 3'd4,
        ST_PUB  = 3'd5
    } state_e;

endpackage

// File: rtl/mmp_sat16.sv
// Combinational Q1.3 descale (arithmetic shift right by 3, floor) of a signed
// accumulator followed by signed saturation to 16 bits with a clip flag.
module mmp_sat16
    import mmp_dac_pkg::*;
(
    input  logic [ACC_W-1:0] acc_i,
    output logic [SMP_W-1:0] sat_o,
    output logic             clip_o
);

    logic [ACC_W-4:0] shr_s;

    // Dropping the low three bits of a two's-complement value is a floor divide by 8.
    always_comb begin
        shr_s = acc_i[ACC_W-1:3];
        if (shr_s[ACC_W-4:SMP_W-1] == {(ACC_W-SMP_W-2){shr_s[SMP_W-1]}}) begin
            sat_o  = shr_s[SMP_W-1:0];
            clip_o = 1'b0;
        end else begin
            sat_o  = shr_s[ACC_W-4] ? 16'h8000 : 16'h7FFF;
            clip_o = 1'b1;
        end
    end

endmodule

// File: rtl/mmp_dac_mixsched.sv
// Frame-synchronous mix scheduler: snapshots SCC/PSG/OPLL samples on a frame
// request, mixes them through one shared MAC and publishes four coherent words.
module mmp_dac_mixsched
    import mmp_dac_pkg::*;
(
    input  logic        i_CLK,
    input  logic        i_RST_n,
    input  logic [15:0] i_SCC,
    input  logic [15:0] i_PSG,
    input  logic [15:0] i_OPLL,
    input  logic        i_SCC_VLD,
    input  logic        i_PSG_VLD,
    input  logic        i_OPLL_VLD,
    input  logic        i_CFG_WE,
    input  logic [1:0]  i_CFG_ADDR,
    input  logic [7:0]  i_CFG_DATA,
    input  logic        i_FRAME_REQ,
    output logic [15:0] o_SCC,
    output logic [15:0] o_PSG,
    output logic [15:0] o_OPLL,
    output logic [15:0] o_ALL,
    output logic        o_FRAME_DONE,
    output logic        o_BUSY,
    output logic        o_CLIP,
    output logic        o_OVR
);

    localparam int PROD_W = SMP_W + GAIN_W + 1;

    state_e                   state_q, state_d;
    logic [2:0][SMP_W-1:0]    hold_q, hold_d, smp_q, smp_d;
    logic [2:0][GAIN_W-1:0]   gain_q, gain_d, wgain_q, wgain_d;
    logic [2:0]               mute_q, mute_d, wmute_q, wmute_d;
    logic                     en_q, en_d, wen_q, wen_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [SMP_W-1:0]         all_q, all_d;
    logic [3:0][SMP_W-1:0]    out_q, out_d;
    logic                     done_q, done_d, busy_q, busy_d;
    logic                     clip_q, clip_d, ovr_q, ovr_d;

    logic [1:0]               idx_s;
    logic [PROD_W-1:0]        smp_ext_s, gain_ext_s, prod_s;
    logic [ACC_W-1:0]         term_s;
    logic [SMP_W-1:0]         sat_s;
    logic                     sat_clip_s, clip_set_s, clr_s;

    mmp_sat16 u_sat (
        .acc_i  (acc_q),
        .sat_o  (sat_s),
        .clip_o (sat_clip_s)
    );

    // Shared MAC operand select; low PROD_W bits of the product are sign-correct.
    always_comb begin
        case (state_q)
            ST_MAC1: idx_s = 2'd1;
            ST_MAC2: idx_s = 2'd2;
            default: idx_s = 2'd0;
        endcase
        smp_ext_s  = {{(PROD_W-SMP_W){smp_q[idx_s][SMP_W-1]}}, smp_q[idx_s]};
        gain_ext_s = {{(PROD_W-GAIN_W){1'b0}}, wgain_q[idx_s]};
        prod_s     = smp_ext_s * gain_ext_s;
        if (wmute_q[idx_s]) begin
            term_s = '0;
        end else begin
            term_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
        end
    end

    // Next-state logic for the FSM, holding/config registers and output words.
    always_comb begin
        state_d    = state_q;
        smp_d      = smp_q;
        wgain_d    = wgain_q;
        wmute_d    = wmute_q;
        wen_d      = wen_q;
        acc_d      = acc_q;
        all_d      = all_q;
        out_d      = out_q;
        gain_d     = gain_q;
        mute_d     = mute_q;
        en_d       = en_q;
        done_d     = 1'b0;
        clip_set_s = 1'b0;

        hold_d[0] = i_SCC_VLD  ? i_SCC  : hold_q[0];
        hold_d[1] = i_PSG_VLD  ? i_PSG  : hold_q[1];
        hold_d[2] = i_OPLL_VLD ? i_OPLL : hold_q[2];

        if (i_CFG_WE) begin
            case (i_CFG_ADDR)
                CFG_MASTER: en_d = i_CFG_DATA[0];
                default: begin
                    gain_d[i_CFG_ADDR] = i_CFG_DATA[GAIN_W-1:0];
                    mute_d[i_CFG_ADDR] = i_CFG_DATA[7];
                end
            endcase
        end else begin
            en_d = en_q;
        end
        clr_s = i_CFG_WE && (i_CFG_ADDR == CFG_MASTER) && i_CFG_DATA[7];

        case (state_q)
            ST_IDLE: begin
                if (i_FRAME_REQ) begin
                    smp_d   = hold_q;
                    wgain_d = gain_q;
                    wmute_d = mute_q;
                    wen_d   = en_q;
                    acc_d   = '0;
                    state_d = ST_MAC0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC0: begin
                acc_d   = acc_q + term_s;
                state_d = ST_MAC1;
            end
            ST_MAC1: begin
                acc_d   = acc_q + term_s;
                state_d = ST_MAC2;
            end
            ST_MAC2: begin
                acc_d   = acc_q + term_s;
                state_d = ST_SAT;
            end
            ST_SAT: begin
                all_d      = sat_s;
                clip_set_s = wen_q & sat_clip_s;
                state_d    = ST_PUB;
            end
            ST_PUB: begin
                for (int k = 0; k < 3; k++) begin
                    out_d[k] = (wen_q && !wmute_q[k]) ? smp_q[k] : '0;
                end
                out_d[3] = wen_q ? all_q : '0;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A set in the same cycle as a clear wins.
        clip_d = clip_set_s | (~clr_s & clip_q);
        ovr_d  = (i_FRAME_REQ && (state_q != ST_IDLE)) | (~clr_s & ovr_q);
        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            smp_q   <= '0;
            gain_q  <= {3{GAIN_W'(GAIN_UNITY)}};
            wgain_q <= {3{GAIN_W'(GAIN_UNITY)}};
            mute_q  <= 3'b000;
            wmute_q <= 3'b000;
            en_q    <= 1'b1;
            wen_q   <= 1'b1;
            acc_q   <= '0;
            all_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            clip_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            smp_q   <= smp_d;
            gain_q  <= gain_d;
            wgain_q <= wgain_d;
            mute_q  <= mute_d;
            wmute_q <= wmute_d;
            en_q    <= en_d;
            wen_q   <= wen_d;
            acc_q   <= acc_d;
            all_q   <= all_d;
            out_q   <= out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            clip_q  <= clip_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_SCC        = out_q[0];
    assign o_PSG        = out_q[1];
    assign o_OPLL       = out_q[2];
    assign o_ALL        = out_q[3];
    assign o_FRAME_DONE = done_q;
    assign o_BUSY       = busy_q;
    assign o_CLIP       = clip_q;
    assign o_OVR        = ovr_q;

endmodule

// File: tb/tb_mmp_dac_mixsched.sv
// Directed bench for mmp_dac_mixsched: expected frames are queued when a
// request is issued and compared when o_FRAME_DONE appears.
module tb_mmp_dac_mixsched;

    typedef struct {
        logic signed [31:0] scc;
        logic signed [31:0] psg;
        logic signed [31:0] opll;
        logic signed [31:0] all;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] scc, psg, opll;
    logic               scc_vld, psg_vld, opll_vld;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic [7:0]         cfg_data;
    logic               frame_req;
    logic signed [15:0] o_scc, o_psg, o_opll, o_all;
    logic               done, busy, clip, ovr;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mmp_dac_mixsched dut (
        .i_CLK        (clk),
        .i_RST_n      (rst_n),
        .i_SCC        (scc),
        .i_PSG        (psg),
        .i_OPLL       (opll),
        .i_SCC_VLD    (scc_vld),
        .i_PSG_VLD    (psg_vld),
        .i_OPLL_VLD   (opll_vld),
        .i_CFG_WE     (cfg_we),
        .i_CFG_ADDR   (cfg_addr),
        .i_CFG_DATA   (cfg_data),
        .i_FRAME_REQ  (frame_req),
        .o_SCC        (o_scc),
        .o_PSG        (o_psg),
        .o_OPLL       (o_opll),
        .o_ALL        (o_all),
        .o_FRAME_DONE (done),
        .o_BUSY       (busy),
        .o_CLIP       (clip),
        .o_OVR        (ovr)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic load(input int s, input int p, input int o);
        scc = 16'(s); psg = 16'(p); opll = 16'(o);
        scc_vld = 1'b1; psg_vld = 1'b1; opll_vld = 1'b1;
        tick();
        scc_vld = 1'b0; psg_vld = 1'b0; opll_vld = 1'b0;
    endtask

    task automatic check_outs(input string tag, input exp_t e);
        check({tag, "_scc"},  o_scc,  e.scc);
        check({tag, "_psg"},  o_psg,  e.psg);
        check({tag, "_opll"}, o_opll, e.opll);
        check({tag, "_all"},  o_all,  e.all);
    endtask

    // Issue a request at edge N (optional second request at N+req2), expect done at N+5.
    task automatic do_frame(input string tag, input exp_t e, input int req2);
        int   lat;
        exp_t got;
        sb_q.push_back(e);
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        scc_vld = 1'b0; psg_vld = 1'b0; opll_vld = 1'b0; cfg_we = 1'b0;
        check({tag, "_busy_start"}, busy, 1);
        lat = 0;
        while (!done && lat < 10) begin
            frame_req = (lat + 1 == req2);
            tick();
            lat++;
        end
        frame_req = 1'b0;
        check({tag, "_done_lat"}, lat, 5);
        got = sb_q.pop_front();
        check_outs(tag, got);
        check({tag, "_busy_end"}, busy, 0);
        tick();
        check({tag, "_done_pulse"}, done, 0);
        check_outs({tag, "_hold"}, got);
    endtask

    initial begin
        int n_done;
        rst_n = 1'b0; scc = '0; psg = '0; opll = '0;
        scc_vld = 1'b0; psg_vld = 1'b0; opll_vld = 1'b0;
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 8'h00; frame_req = 1'b0;
        repeat (3) tick();
        check_outs("rst", '{0, 0, 0, 0});
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_clip", clip, 0);
        check("rst_ovr", ovr, 0);
        rst_n = 1'b1;
        tick();

        do_frame("zero", '{0, 0, 0, 0}, 0);

        load(1000, 2000, -500);
        do_frame("unity", '{1000, 2000, -500, 2500}, 0);
        check("unity_clip", clip, 0);

        cfg(2'd0, 8'h0F); cfg(2'd1, 8'h0F); cfg(2'd2, 8'h0F);
        load(30000, 30000, 30000);
        do_frame("satpos", '{30000, 30000, 30000, 32767}, 0);
        check("satpos_clip", clip, 1);
        load(-32768, -32768, -32768);
        do_frame("satneg", '{-32768, -32768, -32768, -32768}, 0);
        cfg(2'd3, 8'h81);
        check("clip_clear", clip, 0);

        cfg(2'd0, 8'h04); cfg(2'd1, 8'h80);
        load(1001, 5000, 0);
        do_frame("gainpos", '{1001, 0, 0, 500}, 0);
        load(-1001, 5000, 0);
        do_frame("gainneg", '{-1001, 0, 0, -501}, 0);
        check("gain_clip", clip, 0);

        do_frame("ovr", '{-1001, 0, 0, -501}, 2);
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) n_done++;
        end
        check("ovr_extra_done", n_done, 0);
        check("ovr_flag", ovr, 1);
        cfg(2'd3, 8'h81);
        check("ovr_clear", ovr, 0);

        cfg(2'd3, 8'h00);
        do_frame("disabled", '{0, 0, 0, 0}, 0);
        cfg(2'd3, 8'h01);

        scc = 16'sd7; scc_vld = 1'b1;
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'h08;
        do_frame("coh_old", '{-1001, 0, 0, -501}, 0);
        do_frame("coh_new", '{7, 0, 0, 7}, 0);

        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", busy, 0);
        check_outs("midrst", '{0, 0, 0, 0});
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) n_done++;
        end
        check("midrst_no_done", n_done, 0);
        check_outs("midrst_after", '{0, 0, 0, 0});
        check("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmp_dac_mixsched.md
# mmp_dac_mixsched

Frame-synchronous mix scheduler sitting between the SCC/PSG/OPLL sound generators and the 4-channel I2S DAC serializer. It holds the latest sample from each source and, on every serializer frame request, snapshots them. It computes the gain-weighted ALL mix through one time-shared multiply-accumulate unit, then publishes all four 16-bit words together. The serializer therefore always loads a coherent set, and a host register port configures per-source gain/mute and master enable.

## Interface
- GAIN_W, 4: per-source gain width; gain is unsigned Q1.3 (value/8), unity = 8.
- i_CLK  in  1  system clock; all logic on rising edge.
- i_RST_n  in  1  reset i_RST_n, synchronous, active-low.
- i_SCC / i_PSG / i_OPLL  in  16 each  signed source samples.
- i_SCC_VLD / i_PSG_VLD / i_OPLL_VLD  in  1 each  sample strobe; holding register loads when high.
- i_CFG_WE  in  1  config write strobe.
- i_CFG_ADDR  in  2  0=SCC, 1=PSG, 2=OPLL: data[3:0] gain, data[7] mute. 3=master: data[0] enable, data[7]=1 clears o_OVR.
- i_CFG_DATA  in  8  config write data.
- i_FRAME_REQ  in  1  one-cycle pulse from serializer side, once per DAC frame.
- o_SCC / o_PSG / o_OPLL / o_ALL  out  16 each  signed published words to serializer.
- o_FRAME_DONE  out  1  one-cycle pulse when outputs update.
- o_BUSY  out  1  high while FSM is not IDLE.
- o_CLIP  out  1  sticky; set when ALL saturates, cleared by i_CFG_ADDR=3 write with data[7]=1.
- o_OVR  out  1  sticky; set when i_FRAME_REQ arrives while busy, cleared with o_CLIP.

## Operation
- Reset state: all o_* words 0, o_FRAME_DONE/o_BUSY/o_CLIP/o_OVR 0. Holding registers 0, gains 8, mutes 0, enable 1, FSM IDLE.
- Holding registers: each source register loads on its VLD. The latest value wins, and there is no FIFO.
- States: IDLE -> MAC0 -> MAC1 -> MAC2 -> SAT -> PUB -> IDLE.
- IDLE + i_FRAME_REQ:
  - Snapshot the 3 holding registers, gains, mutes and enable into working registers.
  - A VLD in the same cycle lands in the holding register only and is used next frame.
  - A config write in the same cycle takes effect next frame.
- MACk: acc += (mute_k ? 0 : sample_k × gain_k). acc is 22-bit signed and cleared at snapshot.
- SAT: all = acc >>> 3 (arithmetic, floor). Then saturate to [-32768, 32767]. Set o_CLIP if clamped.
- PUB:
  - All four outputs update in the same cycle, and o_FRAME_DONE pulses.
  - Individual words = snapshot sample, or 0 if muted (no gain applied). o_ALL = saturated mix.
  - If enable=0, all four words publish as 0 and o_CLIP is not updated.
- i_FRAME_REQ while not IDLE is ignored and sets o_OVR. The frame in progress is unaffected.
- Config writes during a frame change registers immediately, but only the next snapshot uses them.
- Reset mid-frame forces IDLE with outputs 0 and no o_FRAME_DONE.

## Timing
- i_FRAME_REQ sampled at edge N means MAC0 at N+1, SAT at N+4, and outputs plus o_FRAME_DONE valid after edge N+5.
- o_BUSY is high from N+1 through N+5 inclusive.
- The minimum request spacing accepted without overrun is 6 cycles. The serializer frame (32 bit-clocks) is always longer.
- Published words hold stable between o_FRAME_DONE pulses.
- o_CLIP and o_OVR set one cycle after their cause. A clear and a set in the same cycle resolve to set.

## Structure
- Package mmp_dac_pkg holds:
  - GAIN_W, GAIN_UNITY=8, ACC_W=22.
  - Config address constants CFG_SCC/PSG/OPLL/MASTER.
  - FSM state enum.
- The sub-module mmp_sat16 performs the combinational arithmetic shift-right-by-3 and signed 22->16 saturation with a clip flag. It is reused later for the master-volume path.

## Test plan
- Reset: hold i_RST_n=0 for 3 cycles. All outputs are 0 and o_BUSY=0. A FRAME_REQ with no VLD publishes all zeros.
- Unity mix: SCC=1000, PSG=2000, OPLL=-500 at default gains, then FRAME_REQ at N. o_ALL=2500, o_SCC=1000, o_PSG=2000, o_OPLL=-500, and o_FRAME_DONE pulses after N+5 only.
- Saturation: all sources 30000 with gain 15 gives o_ALL=32767 and o_CLIP=1. All sources -32768 with gain 15 gives -32768. The clear write drops o_CLIP.
- Gain/mute/rounding: SCC gain 4, PSG mute, PSG=5000, OPLL=0. SCC=1001 gives o_ALL=500 and o_PSG=0. SCC=-1001 gives o_ALL=-501.
- Overrun and coherence:
  - FRAME_REQ at N and N+2 gives exactly one o_FRAME_DONE and o_OVR=1.
  - i_SCC_VLD with 7 at N and a gain write at N both appear only in the next frame.
- Reset mid-frame: i_RST_n=0 at N+3 gives no o_FRAME_DONE, outputs 0, and o_BUSY=0 at N+4.
